// File: rtl/bt656_tx.sv
// BT.656 8-bit video pattern source: EAV / blanking fill / SAV / payload byte
// stream with a divided byte clock and decoded H, V and F flags.
module bt656_tx #(
    parameter int SYS_CLOCK         = 27000000,
    parameter int PIXEL_CLOCK       = 27000000,
    parameter int HACT_PIXELS       = 1440,
    parameter int HBLK_PIXELS       = 276,
    parameter int VACT_LINES_F1     = 240,
    parameter int VBLK_LINES_F1_TOP = 18,
    parameter int VBLK_LINES_F1_BOT = 4,
    parameter int VACT_LINES_F2     = 240,
    parameter int VBLK_LINES_F2_TOP = 18,
    parameter int VBLK_LINES_F2_BOT = 5
) (
    input  logic        i_SysClock,
    input  logic        i_ResetN,
    input  logic        i_TxValid,
    input  logic        i_InterlaceMode,
    input  logic        i_FirstField,
    input  logic [15:0] i_FirstLine,
    output logic [7:0]  o_Data,
    output logic        o_PixelClock,
    output logic        o_Vsignal,
    output logic        o_Hsignal,
    output logic        o_Fsignal
);
    localparam int DIV_N    = SYS_CLOCK / PIXEL_CLOCK;
    localparam int DIV_W    = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam int LINE_LEN = HBLK_PIXELS + HACT_PIXELS;
    localparam int H_W      = $clog2(LINE_LEN);

    localparam logic [H_W-1:0] SAV_START = H_W'(HBLK_PIXELS - 4);
    localparam logic [H_W-1:0] PAY_START = H_W'(HBLK_PIXELS);
    localparam logic [H_W-1:0] LAST_H    = H_W'(LINE_LEN - 1);

    localparam logic [15:0] F1_TOP     = 16'(VBLK_LINES_F1_TOP);
    localparam logic [15:0] F1_ACT_END = 16'(VBLK_LINES_F1_TOP + VACT_LINES_F1);
    localparam logic [15:0] F1_TOTAL   = 16'(VBLK_LINES_F1_TOP + VACT_LINES_F1 + VBLK_LINES_F1_BOT);
    localparam logic [15:0] F2_TOP     = 16'(VBLK_LINES_F2_TOP);
    localparam logic [15:0] F2_ACT_END = 16'(VBLK_LINES_F2_TOP + VACT_LINES_F2);
    localparam logic [15:0] F2_TOTAL   = 16'(VBLK_LINES_F2_TOP + VACT_LINES_F2 + VBLK_LINES_F2_BOT);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_tick;

    logic [H_W-1:0] r_h;
    logic [15:0]    r_line;
    logic           r_field;
    logic           r_interlace;
    logic [7:0]     r_data;
    logic           r_hs;
    logic           r_vs;
    logic           r_fs;

    logic           w_start_f;
    logic [15:0]    w_start_total;
    logic [15:0]    w_start_line;
    logic [H_W-1:0] w_cur_h;
    logic [15:0]    w_cur_line;
    logic           w_cur_f;
    logic           w_cur_il;
    logic [15:0]    w_top;
    logic [15:0]    w_act_end;
    logic [15:0]    w_total;
    logic           w_v;
    logic           w_hs;
    logic [7:0]     w_xy;
    logic [7:0]     w_byte;
    logic [H_W-1:0] w_nxt_h;
    logic [15:0]    w_nxt_line;
    logic           w_nxt_f;

    generate
        if (DIV_N == 1) begin : g_div1
            // Byte rate equals system rate: every cycle carries a byte.
            assign w_tick       = 1'b1;
            assign o_PixelClock = ~i_SysClock;
        end else begin : g_divn
            logic [DIV_W-1:0] r_div;

            // Divide-by-N byte counter; the byte changes when it wraps.
            always_ff @(posedge i_SysClock or negedge i_ResetN) begin
                if (!i_ResetN)                        r_div <= '0;
                else if (r_div == DIV_W'(DIV_N - 1))  r_div <= '0;
                else                                  r_div <= r_div + 1'b1;
            end

            assign w_tick       = (r_div == DIV_W'(DIV_N - 1));
            // Low for the first floor(N/2) cycles, so the rising edge is mid-byte.
            assign o_PixelClock = (r_div >= DIV_W'(DIV_N / 2));
        end
    endgenerate

    // Transmit/idle state: only re-evaluated on byte ticks.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next state: i_TxValid decides at each tick whether the stream continues.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        if (w_tick) w_state_nxt = i_TxValid ? ST_SEND : ST_IDLE;
    end

    // Position of the byte to emit: live start inputs while idle, counters while sending.
    always_comb begin
        w_start_f     = i_InterlaceMode & i_FirstField;
        w_start_total = w_start_f ? F2_TOTAL : F1_TOTAL;
        w_start_line  = (i_FirstLine >= w_start_total) ? 16'd0 : i_FirstLine;

        if (r_state == ST_SEND) begin
            w_cur_h    = r_h;
            w_cur_line = r_line;
            w_cur_f    = r_field;
            w_cur_il   = r_interlace;
        end else begin
            w_cur_h    = '0;
            w_cur_line = w_start_line;
            w_cur_f    = w_start_f;
            w_cur_il   = i_InterlaceMode;
        end
    end

    // Byte and flag decode for the current position.
    always_comb begin
        w_top     = w_cur_f ? F2_TOP     : F1_TOP;
        w_act_end = w_cur_f ? F2_ACT_END : F1_ACT_END;
        w_total   = w_cur_f ? F2_TOTAL   : F1_TOTAL;
        w_v       = (w_cur_line < w_top) || (w_cur_line >= w_act_end);
        w_hs      = (w_cur_h < SAV_START);
        w_xy      = {1'b1, w_cur_f, w_v, w_hs, w_v ^ w_hs, w_cur_f ^ w_hs,
                     w_cur_f ^ w_v, w_cur_f ^ w_v ^ w_hs};

        w_byte = w_cur_h[0] ? 8'h10 : 8'h80;
        if (w_cur_h == H_W'(0) || w_cur_h == SAV_START) begin
            w_byte = 8'hFF;
        end else if (w_cur_h == H_W'(1) || w_cur_h == H_W'(2) ||
                     w_cur_h == SAV_START + H_W'(1) || w_cur_h == SAV_START + H_W'(2)) begin
            w_byte = 8'h00;
        end else if (w_cur_h == H_W'(3) || w_cur_h == SAV_START + H_W'(3)) begin
            w_byte = w_xy;
        end else if (!w_v && w_cur_h >= PAY_START && w_cur_h[0]) begin
            // Luma ramp 0x10..0xEB, one step per Cb/Y/Cr/Y pair member.
            w_byte = 8'(32'h10 + (((32'(w_cur_h) - 32'(HBLK_PIXELS)) >> 1) % 32'd220));
        end
    end

    // Advance h, wrapping into the next line and field.
    always_comb begin
        w_nxt_h    = w_cur_h + 1'b1;
        w_nxt_line = w_cur_line;
        w_nxt_f    = w_cur_f;
        if (w_cur_h == LAST_H) begin
            w_nxt_h = '0;
            if (w_cur_line == w_total - 16'd1) begin
                w_nxt_line = '0;
                w_nxt_f    = w_cur_il & ~w_cur_f;
            end else begin
                w_nxt_line = w_cur_line + 16'd1;
            end
        end
    end

    // Output and position registers, updated only on byte ticks.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_h         <= '0;
            r_line      <= '0;
            r_field     <= 1'b0;
            r_interlace <= 1'b0;
            r_data      <= 8'h10;
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_fs        <= 1'b0;
        end else if (w_tick) begin
            if (i_TxValid) begin
                r_h         <= w_nxt_h;
                r_line      <= w_nxt_line;
                r_field     <= w_nxt_f;
                r_interlace <= w_cur_il;
                r_data      <= w_byte;
                r_hs        <= w_hs;
                if (w_cur_h == H_W'(0)) begin
                    r_vs <= w_v;
                    r_fs <= w_cur_f;
                end
            end else begin
                r_data <= 8'h10;
                r_hs   <= 1'b0;
                r_vs   <= 1'b0;
                r_fs   <= 1'b0;
            end
        end
    end

    assign o_Data    = r_data;
    assign o_Hsignal = r_hs;
    assign o_Vsignal = r_vs;
    assign o_Fsignal = r_fs;

endmodule

// File: tb/tb_bt656_tx.sv
// Bench for bt656_tx: three instances (small N=1, small N=4, default 480i)
// compared every cycle against a position-based stream model.
module tb_bt656_tx;
    localparam int NI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        tx_valid [NI];
    logic        il       [NI];
    logic        ff       [NI];
    logic [15:0] fl       [NI];
    logic [7:0]  data     [NI];
    logic        pclk     [NI];
    logic        vs       [NI];
    logic        hs       [NI];
    logic        fs       [NI];

    // Geometry of each instance, as given to its parameters.
    int g_div  [NI]    = '{1, 4, 1};
    int g_hblk [NI]    = '{12, 12, 276};
    int g_hact [NI]    = '{16, 16, 1440};
    int g_top  [NI][2] = '{'{2, 2}, '{2, 2}, '{18, 18}};
    int g_act  [NI][2] = '{'{4, 4}, '{4, 4}, '{240, 240}};
    int g_bot  [NI][2] = '{'{1, 2}, '{1, 2}, '{4, 5}};

    bt656_tx #(
        .HACT_PIXELS(16), .HBLK_PIXELS(12),
        .VACT_LINES_F1(4), .VBLK_LINES_F1_TOP(2), .VBLK_LINES_F1_BOT(1),
        .VACT_LINES_F2(4), .VBLK_LINES_F2_TOP(2), .VBLK_LINES_F2_BOT(2)
    ) dut_a (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_TxValid(tx_valid[0]),
        .i_InterlaceMode(il[0]), .i_FirstField(ff[0]), .i_FirstLine(fl[0]),
        .o_Data(data[0]), .o_PixelClock(pclk[0]), .o_Vsignal(vs[0]),
        .o_Hsignal(hs[0]), .o_Fsignal(fs[0])
    );

    bt656_tx #(
        .SYS_CLOCK(108000000), .PIXEL_CLOCK(27000000),
        .HACT_PIXELS(16), .HBLK_PIXELS(12),
        .VACT_LINES_F1(4), .VBLK_LINES_F1_TOP(2), .VBLK_LINES_F1_BOT(1),
        .VACT_LINES_F2(4), .VBLK_LINES_F2_TOP(2), .VBLK_LINES_F2_BOT(2)
    ) dut_b (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_TxValid(tx_valid[1]),
        .i_InterlaceMode(il[1]), .i_FirstField(ff[1]), .i_FirstLine(fl[1]),
        .o_Data(data[1]), .o_PixelClock(pclk[1]), .o_Vsignal(vs[1]),
        .o_Hsignal(hs[1]), .o_Fsignal(fs[1])
    );

    bt656_tx dut_c (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_TxValid(tx_valid[2]),
        .i_InterlaceMode(il[2]), .i_FirstField(ff[2]), .i_FirstLine(fl[2]),
        .o_Data(data[2]), .o_PixelClock(pclk[2]), .o_Vsignal(vs[2]),
        .o_Hsignal(hs[2]), .o_Fsignal(fs[2])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        int         cnt;    // system cycles into the current byte
        int         h;      // next byte position in the line
        int         line;
        int         fld;
        logic       on;
        logic       il;
        logic [7:0] d;
        logic       hs;
        logic       vs;
        logic       fs;
    } mstate_t;

    mstate_t m [NI];

    function automatic int field_total(input int i, input int f);
        return g_top[i][f] + g_act[i][f] + g_bot[i][f];
    endfunction

    function automatic logic line_blank(input int i, input int ln, input int f);
        return (ln < g_top[i][f]) || (ln >= g_top[i][f] + g_act[i][f]);
    endfunction

    // Byte at horizontal position h of line ln in field f.
    function automatic logic [7:0] ref_byte(input int i, input int h, input int ln, input int f);
        int   hb = g_hblk[i];
        logic fb = (f != 0);
        logic v  = line_blank(i, ln, f);
        logic hh = (h < hb - 4);
        logic [7:0] xy = {1'b1, fb, v, hh, v ^ hh, fb ^ hh, fb ^ v, fb ^ v ^ hh};
        int   k;
        if (h < 4 || (h >= hb - 4 && h < hb)) begin
            k = (h < 4) ? h : h - (hb - 4);
            if (k == 0) return 8'hFF;
            if (k == 3) return xy;
            return 8'h00;
        end
        if (h < hb) return (((h - 4) % 2) == 0) ? 8'h80 : 8'h10;
        if (!v && ((h - hb) % 2) == 1) return 8'(16 + ((h - hb) / 2) % 220);
        return (((h - hb) % 2) == 0) ? 8'h80 : 8'h10;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t n;
        n = '0;
        n.d = 8'h10;
        return n;
    endfunction

    function automatic mstate_t model_next(input int i, input mstate_t s);
        mstate_t n = s;
        logic tick = (g_div[i] == 1) || (s.cnt == g_div[i] - 1);
        n.cnt = (s.cnt + 1) % g_div[i];
        if (!tick) return n;
        if (!tx_valid[i]) begin
            n.on = 1'b0; n.d = 8'h10; n.hs = 1'b0; n.vs = 1'b0; n.fs = 1'b0;
            return n;
        end
        if (!s.on) begin
            n.on   = 1'b1;
            n.il   = il[i];
            n.fld  = il[i] ? int'(ff[i]) : 0;
            n.line = (int'(fl[i]) >= field_total(i, n.fld)) ? 0 : int'(fl[i]);
            n.h    = 0;
        end
        n.d  = ref_byte(i, n.h, n.line, n.fld);
        n.hs = (n.h < g_hblk[i] - 4);
        if (n.h == 0) begin
            n.vs = line_blank(i, n.line, n.fld);
            n.fs = (n.fld != 0);
        end
        n.h = n.h + 1;
        if (n.h == g_hblk[i] + g_hact[i]) begin
            n.h    = 0;
            n.line = n.line + 1;
            if (n.line == field_total(i, n.fld)) begin
                n.line = 0;
                n.fld  = n.il ? 1 - n.fld : 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) m[i] <= model_reset();
            else        m[i] <= model_next(i, m[i]);
        end
    end

    // One cycle: go to the falling edge and compare every instance.
    task automatic cyc();
        logic exp_pclk;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            exp_pclk = (g_div[i] == 1) ? 1'b1 : (m[i].cnt >= g_div[i] / 2);
            check($sformatf("data%0d", i), 32'(data[i]), 32'(m[i].d));
            check($sformatf("hsig%0d", i), 32'(hs[i]), 32'(m[i].hs));
            check($sformatf("vsig%0d", i), 32'(vs[i]), 32'(m[i].vs));
            check($sformatf("fsig%0d", i), 32'(fs[i]), 32'(m[i].fs));
            check($sformatf("pclk%0d", i), 32'(pclk[i]), 32'(exp_pclk));
        end
    endtask

    logic [7:0] line0_tbl [12] = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10,
                                   8'h80, 8'h10, 8'hFF, 8'h00, 8'h00, 8'hAB};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        for (int i = 0; i < NI; i++) begin
            tx_valid[i] = 1'b0; il[i] = 1'b0; ff[i] = 1'b0; fl[i] = 16'd0;
        end
        repeat (3) cyc();
        check("reset_data", 32'(data[0]), 32'h10);
        check("reset_pclk_n4", 32'(pclk[1]), 32'h0);
        rst_n = 1'b1;
        cyc();

        // A: progressive from line 0; B: interlaced from F1; C: 480i from F2 line 260.
        il[0] = 1'b0; fl[0] = 16'd0; tx_valid[0] = 1'b1;
        il[1] = 1'b1; ff[1] = 1'b0; fl[1] = 16'd0; tx_valid[1] = 1'b1;
        il[2] = 1'b1; ff[2] = 1'b1; fl[2] = 16'd260; tx_valid[2] = 1'b1;
        for (int k = 0; k <= 3 * 1716 + 3; k++) begin
            cyc();
            if (k < 12)              check("a_line0", 32'(data[0]), 32'(line0_tbl[k]));
            if (k == 59)             check("a_l2_eav_xy", 32'(data[0]), 32'h9D);
            if (k == 67)             check("a_l2_sav_xy", 32'(data[0]), 32'h80);
            if (k == 69)             check("a_l2_y0", 32'(data[0]), 32'h10);
            if (k == 71)             check("a_l2_y1", 32'(data[0]), 32'h11);
            if (k == 83)             check("a_l2_y7", 32'(data[0]), 32'h17);
            if (k == 199)            check("a_wrap_xy", 32'(data[0]), 32'hB6);
            if (k == 3)              check("c_f2_eav_xy", 32'(data[2]), 32'hF1);
            if (k == 3)              check("c_f2_fsig", 32'(fs[2]), 32'h1);
            if (k == 275)            check("c_f2_sav_xy", 32'(data[2]), 32'hEC);
            if (k == 3 * 1716)       check("c_f1_fsig", 32'(fs[2]), 32'h0);
            if (k == 3 * 1716 + 3)   check("c_f1_eav_xy", 32'(data[2]), 32'hB6);
        end

        // Drop A mid-active-line, then restart from line 3.
        waited = 0;
        while (!(m[0].on && m[0].h == 20 && !m[0].vs) && waited < 500) begin
            cyc();
            waited++;
        end
        check("wait_active", 32'(waited < 500), 32'h1);
        tx_valid[0] = 1'b0;
        cyc();
        check("drop_data", 32'(data[0]), 32'h10);
        check("drop_flags", {29'd0, hs[0], vs[0], fs[0]}, 32'h0);
        fl[0] = 16'd3; tx_valid[0] = 1'b1;
        cyc();
        check("restart_ff", 32'(data[0]), 32'hFF);

        // Randomized starts, drops and input changes on A and B; C idles.
        tx_valid[2] = 1'b0;
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < 2; i++) begin
                il[i]       = 1'($urandom_range(0, 1));
                ff[i]       = 1'($urandom_range(0, 1));
                fl[i]       = 16'($urandom_range(0, 9));
                tx_valid[i] = ($urandom_range(0, 4) != 0);
            end
            repeat ($urandom_range(1, 150)) cyc();
        end

        // Asynchronous reset in the middle of a frame.
        tx_valid[0] = 1'b1; tx_valid[1] = 1'b1;
        repeat (50) cyc();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("areset_data", 32'(data[0]), 32'h10);
        check("areset_flags", {29'd0, hs[0], vs[0], fs[0]}, 32'h0);
        check("areset_pclk", 32'(pclk[1]), 32'h0);
        cyc();
        rst_n = 1'b1;
        repeat (200) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bt656_tx.md
Name: bt656_tx

Overview:
- ITU-R BT.656 8-bit video source (pattern generator). Emits an EAV/blanking/SAV/active byte stream with its own pixel clock and decoded H/V/F flags.
- Frame geometry is set by parameters. Progressive or interlaced mode, starting field and starting line are run-time inputs.
- Sits at the video output edge, or drives BT.656 receivers under test.

Parameters:
- SYS_CLOCK, 27000000: system clock frequency, Hz.
- PIXEL_CLOCK, 27000000: byte clock, Hz. SYS_CLOCK/PIXEL_CLOCK must be an integer N ≥ 1.
- HACT_PIXELS, 1440: active bytes per line; even.
- HBLK_PIXELS, 276: horizontal blanking bytes, including EAV and SAV; even, ≥ 8.
- VACT_LINES_F1, 240: active lines, field 1.
- VBLK_LINES_F1_TOP, 18: blank lines before active, field 1.
- VBLK_LINES_F1_BOT, 4: blank lines after active, field 1.
- VACT_LINES_F2, 240: active lines, field 2.
- VBLK_LINES_F2_TOP, 18: blank lines before active, field 2.
- VBLK_LINES_F2_BOT, 5: blank lines after active, field 2.

Ports:
- i_SysClock  in  1  system clock, single clock domain.
- i_ResetN  in  1  reset, asynchronous, active-low.
- i_TxValid  in  1  1 = transmit, 0 = idle.
- i_InterlaceMode  in  1  0 = progressive, 1 = interlaced.
- i_FirstField  in  1  starting field: 0 = odd (F1), 1 = even (F2).
- i_FirstLine  in  16  starting line index within the starting field.
- o_Data  out  8  BT.656 byte stream.
- o_PixelClock  out  1  byte clock.
- o_Vsignal  out  1  V flag of the current line.
- o_Hsignal  out  1  H flag of the current byte.
- o_Fsignal  out  1  F flag of the current line.

Behaviour:
- Pixel tick:
  - N=1: tick every i_SysClock cycle; o_PixelClock = ~i_SysClock.
  - N≥2: divide-by-N counter. o_PixelClock low for floor(N/2) cycles, then high; rises mid-way through each byte.
  - All data and flag outputs change only on ticks.
- Reset and idle values: o_Data=0x10, o_Hsignal=0, o_Vsignal=0, o_Fsignal=0, o_PixelClock=0 (N≥2).
- Idle (i_TxValid=0, sampled each cycle):
  - Outputs hold idle values.
  - h=0; field = i_FirstField (forced to 0 when progressive); line = i_FirstLine, or 0 if i_FirstLine ≥ field total.
  - Dropping i_TxValid mid-stream returns to idle at the next tick.
- Start: the byte at h=0 of the start line (0xFF) appears on the first tick after i_TxValid is sampled high. One tick of latency.
- Line of L = HBLK+HACT bytes, h = 0..L-1:
  - h 0..3: EAV = FF 00 00 XY(H=1).
  - h 4..HBLK-5: fill alternating 0x80, 0x10, starting with 0x80.
  - h HBLK-4..HBLK-1: SAV = FF 00 00 XY(H=0).
  - h ≥ HBLK: payload.
- Payload:
  - Blank lines (V=1): same 0x80/0x10 fill.
  - Active lines: even offset → 0x80 (Cb/Cr); odd offset → Y = 0x10 + (((h-HBLK)>>1) mod 220).
  - 0x00 and 0xFF never appear outside EAV/SAV.
- XY byte: bit7=1, bit6=F, bit5=V, bit4=H, bit3=V^H, bit2=F^H, bit1=F^V, bit0=F^V^H.
- Field layout:
  - Field f has TOP blank lines (V=1), then ACT lines (V=0), then BOT blank lines (V=1).
  - Field total = TOP+ACT+BOT.
  - Interlaced: F1 (F=0) then F2 (F=1), repeating.
  - Progressive: F1 parameters only, F=0 always.
- Wrap:
  - h=L-1 → h=0 and line+1.
  - Last line of a field → line 0 of the next field; progressive stays in F1.
- Flags:
  - o_Hsignal=1 from h=0 through h=HBLK-5; 0 from h=HBLK-4 through h=L-1.
  - o_Vsignal and o_Fsignal update on the tick carrying h=0 (EAV first byte) of each line.
- Input changes take effect only when starting from idle.

Test Plan:
- Progressive, N=1, HACT=16, HBLK=12, F1 2/4/1 (top/act/bot), start line 0 → line 0 is FF 00 00 B6, 80 10 80 10, FF 00 00 AB, then 16 blank bytes. Line 2 EAV XY=9D, SAV XY=80, payload 80 10 80 11 … 80 17. Line 7 wraps to line 0; F stays 0.
- Interlaced, same geometry with F2 2/4/2 (top/act/bot) → line order F1 7 lines, then F2 8 lines. F2 active XY: EAV DA, SAV C7. F2 blank XY: EAV F1, SAV EC. o_Fsignal toggles at h=0.
- Default 480i parameters, i_FirstField=1, i_FirstLine=260 → first line is F2 bottom blank (XY F1/EC). After 3 lines, F1 line 0. o_Vsignal rises, falls, rises, falls within 2 fields.
- N=4 → one byte every 4 cycles; o_PixelClock low for 2 cycles, high for 2; data stable across each rising edge.
- Deassert i_TxValid mid-active-line → next tick o_Data=0x10, all flags 0. Reassert → restart with FF at i_FirstLine, h=0.
- Async reset asserted mid-frame → outputs go to reset values immediately, without waiting for a clock edge.
